// File: rtl/sort_pkg.sv
// Shared types and defaults for the sequential bubble sorter.
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_t;

    localparam int SORT_N = 4;
    localparam int SORT_W = 8;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mag_cmp.sv
// Unsigned W-bit magnitude comparator; exactly one of eq/lt/gt is high.
module mag_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         lt,
    output logic         gt
);

    assign eq = (a == b);
    assign lt = (a < b);
    assign gt = !eq && !lt;

endmodule

// File: rtl/sort_ctrl.sv
// Loads N words, bubble-sorts them with one shared comparator
// (one compare-and-swap per clock), then streams them out ascending.
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int W = SORT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int IW = idx_w(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [IW-1:0] PMAX = IW'(N - 2);
    localparam logic [IW-1:0] ONE  = IW'(1);

    state_t state_q, state_d;

    logic [W-1:0]  data_q [N];
    logic [IW-1:0] wr_idx, rd_idx, p, j;
    logic [IW-1:0] j_nx, j_end;
    logic [W-1:0]  op_a, op_b;
    logic          cmp_eq, cmp_lt, cmp_gt;
    logic          swap, accept, out_hs;

    assign j_nx  = j + ONE;
    assign j_end = PMAX - p;
    assign op_a  = data_q[j];
    assign op_b  = data_q[j_nx];

    mag_cmp #(.W(W)) u_cmp (
        .a  (op_a),
        .b  (op_b),
        .eq (cmp_eq),
        .lt (cmp_lt),
        .gt (cmp_gt)
    );

    // Ties never swap, which keeps equal values in arrival order.
    assign swap = ({cmp_gt, cmp_eq, cmp_lt} == 3'b100);

    assign in_ready  = (state_q == LOAD);
    assign busy      = !in_ready;
    assign out_valid = (state_q == DRAIN);
    assign out_last  = out_valid && (rd_idx == LAST);
    assign out_data  = out_valid ? data_q[rd_idx] : '0;
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:  if (accept && wr_idx == LAST) state_d = SORT;
            // The final pass holds a single pair, so p alone marks the last step.
            SORT:  if (p == PMAX) state_d = DRAIN;
            DRAIN: if (out_hs && rd_idx == LAST) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            wr_idx  <= '0;
            rd_idx  <= '0;
            p       <= '0;
            j       <= '0;
            for (int i = 0; i < N; i++) data_q[i] <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                LOAD: begin
                    if (accept) begin
                        data_q[wr_idx] <= in_data;
                        wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + ONE;
                    end
                end
                SORT: begin
                    if (swap) begin
                        data_q[j]    <= op_b;
                        data_q[j_nx] <= op_a;
                    end
                    if (j == j_end) begin
                        j <= '0;
                        p <= (p == PMAX) ? '0 : p + ONE;
                    end else begin
                        j <= j_nx;
                    end
                end
                DRAIN: begin
                    if (out_hs) rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_ctrl.sv
// Scoreboard bench for sort_ctrl with N=4, W=8.
module tb_sort_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int tests = 0;
    int fails = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    sort_ctrl #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic chk_idle(input string tag);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 ||
            out_last !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: rdy=%b vld=%b data=%0d last=%b busy=%b, need 1 0 0 0 0",
                     tag, in_ready, out_valid, out_data, out_last, busy);
        end
    endtask

    // Drives one batch; pat bit c set means in_valid high in cycle c.
    task automatic load(input logic [7:0] v [4], input int len, input logic [15:0] pat);
        logic [7:0] s [4];
        logic [7:0] t;
        int n;
        n = 0;
        s = v;
        for (int i = 1; i < 4; i++)
            for (int k = i; k > 0; k--)
                if (s[k-1] > s[k]) begin
                    t = s[k]; s[k] = s[k-1]; s[k-1] = t;
                end
        for (int i = 0; i < 4; i++) sb.push_back(s[i]);
        for (int c = 0; c < len; c++) begin
            in_valid = pat[c];
            in_data  = pat[c] ? v[n] : 8'hEE;
            tests++;
            if (in_ready !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL load_ready c=%0d: rdy=%b busy=%b, need 1 0", c, in_ready, busy);
            end
            @(negedge clk);
            if (pat[c]) n++;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Called at the falling edge right after the 4th accept.
    task automatic wait_sort(input int exp, input bit poke);
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            tests++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL sort_block k=%0d: rdy=%b busy=%b, need 0 1", k, in_ready, busy);
            end
            if (poke) begin
                in_valid = 1'b1;
                in_data  = 8'd99;
            end
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        tests++;
        if (k !== exp) begin
            fails++;
            $display("FAIL sort_cycles: got %0d, need %0d", k, exp);
        end
    endtask

    task automatic drain(input int stall_idx);
        logic [7:0] e;
        int k;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (out_valid !== 1'b1 && k < 40) begin
                @(negedge clk);
                k++;
            end
            tests++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                fails++;
                $display("FAIL drain_timeout i=%0d: vld=%b sb=%0d", i, out_valid, sb.size());
                return;
            end
            e = sb.pop_front();
            if (i == stall_idx) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = 8'd99;
                repeat (5) begin
                    @(negedge clk);
                    tests++;
                    if (out_data !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                        fails++;
                        $display("FAIL stall_hold: data=%0d vld=%b rdy=%b, need %0d 1 0",
                                 out_data, out_valid, in_ready, e);
                    end
                end
                in_valid  = 1'b0;
                in_data   = 8'h00;
                out_ready = 1'b1;
            end
            tests++;
            if (out_data !== e) begin
                fails++;
                $display("FAIL out_data i=%0d: got %0d, need %0d", i, out_data, e);
            end
            tests++;
            if (out_last !== logic'(i == 3)) begin
                fails++;
                $display("FAIL out_last i=%0d: got %b, need %b", i, out_last, i == 3);
            end
            @(negedge clk);
        end
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reload: rdy=%b busy=%b vld=%b, need 1 0 0", in_ready, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        #2;
        chk_idle("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("reset_released");
    endtask

    task automatic test_basic();
        load('{8'd30, 8'd10, 8'd20, 8'd5}, 4, 16'hF);
        wait_sort(6, 1'b0);
        drain(-1);
    endtask

    task automatic test_duplicates();
        load('{8'd7, 8'd7, 8'd3, 8'd7}, 4, 16'hF);
        wait_sort(6, 1'b0);
        drain(-1);
    endtask

    task automatic test_timing();
        load('{8'd1, 8'd2, 8'd3, 8'd4}, 4, 16'hF);
        wait_sort(6, 1'b0);
        drain(-1);
        load('{8'd255, 8'd128, 8'd1, 8'd0}, 4, 16'hF);
        wait_sort(6, 1'b0);
        drain(-1);
    endtask

    task automatic test_backpressure();
        load('{8'd50, 8'd40, 8'd60, 8'd45}, 4, 16'hF);
        wait_sort(6, 1'b1);
        drain(1);
    endtask

    task automatic test_gaps();
        load('{8'd9, 8'd4, 8'd6, 8'd2}, 7, 16'b1011001);
        wait_sort(6, 1'b0);
        drain(-1);
    endtask

    task automatic test_reset_mid_sort();
        load('{8'd200, 8'd100, 8'd150, 8'd50}, 4, 16'hF);
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_sort_busy: got %b, need 1", busy);
        end
        rst_n = 1'b0;
        #1;
        chk_idle("reset_async");
        sb.delete();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("reset_after");
        load('{8'd4, 8'd3, 8'd2, 8'd1}, 4, 16'hF);
        wait_sort(6, 1'b0);
        drain(-1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duplicates();
        test_timing();
        test_backpressure();
        test_gaps();
        test_reset_mid_sort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sort_ctrl.md
# sort_ctrl

Sequential sorter that takes N unsigned W-bit words over a valid/ready input stream and returns them in ascending order over a valid/ready output stream. It shares one W-bit magnitude-comparator instance across all comparisons, one compare-and-swap step per clock, using bubble-sort order. It sits downstream of any byte producer that needs ordered data.

## Interface
- `N`, default 4: number of entries per batch; legal range 2..8.
- `W`, default 8: data width in bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts input; high only in LOAD.
- `in_data`  in  W  unsigned input word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts output.
- `out_data`  out  W  sorted word, smallest first.
- `out_last`  out  1  marks the N-th output word.
- `busy`  out  1  high when state is not LOAD.

## Operation
- **States:** LOAD → SORT → DRAIN → LOAD.
- **LOAD**
  - `in_ready` = 1.
  - Each cycle with `in_valid` && `in_ready` writes `in_data` to `buf[wr_idx]` and increments `wr_idx`.
  - The N-th accept moves the state to SORT and clears `wr_idx`.
- **SORT**
  - Pass index `p` runs 0..N-2. Pair index `j` runs 0..N-2-p.
  - Each cycle compares `buf[j]` (A) with `buf[j+1]` (B) in the shared comparator.
  - If A is greater than B, the two entries swap at the clock edge.
  - If A is equal to or less than B, there is no swap, so equal values keep their order.
  - After the compare at `p` = N-2, `j` = 0, the state moves to DRAIN.
  - The step count is always N(N-1)/2 and never depends on the data. There is no early exit.
- **DRAIN**
  - `out_valid` = 1 and `out_data` = `buf[rd_idx]`.
  - `out_last` = 1 when `rd_idx` = N-1.
  - Each handshake increments `rd_idx`.
  - The handshake with `out_last` = 1 clears `rd_idx` and moves the state to LOAD.
- Inputs are ignored in SORT and DRAIN: `in_ready` = 0 and `in_valid` has no effect.
- **Arithmetic:** comparison is unsigned, full W bits. Index registers are clog2(N) bits wide. `j` wraps to 0 at the end of each pass.

## Timing
- **Reset values:** state LOAD, `buf` all 0, every index 0, `in_ready` 1, `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0.
- **Latency:** let the N-th input accept happen at edge t0.
  - SORT occupies the cycles from t0 to t0+N(N-1)/2.
  - `out_valid` rises after edge t0+N(N-1)/2. For N=4 that is 6 edges after t0.
- **Output stability:** `out_data`, `out_valid` and `out_last` are registered or decoded from registered state only. They hold stable while `out_ready` = 0.
- **Throughput:** one word per cycle in LOAD and in DRAIN under continuous valid/ready.
- **LOAD after DRAIN:** `in_ready` rises in the cycle after the final output handshake. There is no overlap between DRAIN and the next LOAD.
- **Reset mid-operation:** `rst_n` low in any state immediately forces all reset values. A partially loaded or sorted batch is discarded.

## Structure
- **Package `sort_pkg`:**
  - state encoding LOAD/SORT/DRAIN;
  - default constants `N`, `W`;
  - function `idx_w(N)` = clog2(N).
- **Sub-module `mag_cmp`:**
  - combinational, W-bit unsigned;
  - outputs `eq`, `lt`, `gt`, exactly one high;
  - instantiated once, with operands muxed from `buf[j]` and `buf[j+1]`.
- **Top level:** FSM, index counters, `buf` register array and swap logic.

## Test plan
- **Basic sort:** N=4, load 30, 10, 20, 5 back-to-back → outputs 5, 10, 20, 30. `out_last` high only with 30. `out_valid` first high exactly 6 edges after the 4th accept.
- **Duplicates:** load 7, 7, 3, 7 → outputs 3, 7, 7, 7.
- **Data-independent timing:** load 1, 2, 3, 4, then in a separate batch 255, 128, 1, 0 → outputs 1, 2, 3, 4 and 0, 1, 128, 255. Both batches spend exactly 6 cycles in SORT.
- **Output backpressure and input blocking:**
  - Hold `out_ready` low for 5 cycles after the 2nd output → `out_data` holds the 2nd word. Nothing is dropped or duplicated. `in_ready` stays 0.
  - Drive `in_valid` during SORT with value 99 → 99 never appears in the output.
- **Input gaps:** toggle `in_valid` 1, 0, 0, 1, 1, 0, 1 with values 9, 4, 6, 2 → outputs 2, 4, 6, 9. `wr_idx` advances only on handshakes.
- **Reset mid-sort:** pulse `rst_n` low during the 3rd SORT cycle → all outputs take their reset values asynchronously. Then load 4, 3, 2, 1 → outputs 1, 2, 3, 4 with no leftover words from the aborted batch.
